// File: rtl/sram_responder_pkg.sv
// sram_responder_pkg: shared FSM state type, counter width and inactive strobe levels.
package sram_responder_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, ACK, RECOVER} resp_state_t;
  localparam int WAIT_CNT_W = 4;
  localparam logic STROBE_OFF = 1'b1;
  localparam logic DQ_OE_OFF = 1'b0;
endpackage

// File: rtl/sram_pin_ctrl.sv
// sram_pin_ctrl: registers every SRAM pin from next-state decode so the strobes are glitch-free.
module sram_pin_ctrl
  import sram_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  resp_state_t i_state,
  input  resp_state_t i_state_nxt,
  input  logic        i_load,
  input  logic        i_wr,
  input  logic [1:0]  i_bytesel,
  input  logic [18:0] i_addr,
  input  logic [15:0] i_data,
  output logic [18:0] o_addr,
  output logic [15:0] o_dq_o,
  output logic        o_dq_oe,
  output logic        o_ce_n,
  output logic        o_oe_n,
  output logic        o_we_n,
  output logic        o_ub_n,
  output logic        o_lb_n
);
  logic w_acc, w_oe_n, w_dq_oe;
  always_comb begin
    w_acc = i_state_nxt == ACCESS;
    w_oe_n = ~(w_acc & ~i_wr);
    w_dq_oe = w_acc & i_wr & w_oe_n;
  end
  // we_n stays high on the first ACCESS cycle (entered from IDLE) for address setup
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      o_addr <= '0;
      o_dq_o <= '0;
      o_dq_oe <= DQ_OE_OFF;
      o_ce_n <= STROBE_OFF;
      o_oe_n <= STROBE_OFF;
      o_we_n <= STROBE_OFF;
      o_ub_n <= STROBE_OFF;
      o_lb_n <= STROBE_OFF;
    end else begin
      o_dq_oe <= w_dq_oe;
      o_ce_n <= ~w_acc;
      o_oe_n <= w_oe_n;
      o_we_n <= ~(w_acc & i_wr & (i_state == ACCESS));
      o_ub_n <= ~(w_acc & i_bytesel[1]);
      o_lb_n <= ~(w_acc & i_bytesel[0]);
      if (i_load) begin
        o_addr <= i_addr;
        o_dq_o <= i_data;
      end
    end
endmodule

// File: rtl/sram_responder.sv
// sram_responder: one-word-at-a-time async SRAM responder with parameterised wait states.
// Define SRAM_RESPONDER_POSTED_WRITE_EN to ack writes in the first ACCESS cycle.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:1] m_addr,
  input  logic [15:0] m_data_in,
  output logic [15:0] m_data_out,
  input  logic        m_access,
  output logic        m_ack,
  input  logic        m_wr_en,
  input  logic [1:0]  m_bytesel,
  output logic [18:0] sram_addr,
  output logic [15:0] sram_dq_o,
  input  logic [15:0] sram_dq_i,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);
  resp_state_t r_state, w_state_nxt;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic [18:0] r_addr, w_addr;
  logic [15:0] r_data, w_data;
  logic [1:0] r_bytesel, w_bytesel;
  logic r_wr, w_wr, w_cap, w_last, r_wack_blk;
  always_comb begin
    w_cap = r_state == IDLE && m_access;
    w_last = r_state == ACCESS && r_wait_cnt == '0;
    w_state_nxt = w_cap ? ACCESS : w_last ? ACK : r_state == ACK ? RECOVER : r_state == RECOVER ? IDLE : r_state;
    w_wr = w_cap ? m_wr_en : r_wr;
    w_bytesel = w_cap ? m_bytesel : r_bytesel;
    w_addr = w_cap ? m_addr : r_addr;
    w_data = w_cap ? m_data_in : r_data;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_wait_cnt <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_bytesel <= '0;
      r_wr <= 1'b0;
      r_wack_blk <= 1'b0;
      m_ack <= 1'b0;
      m_data_out <= '0;
    end else begin
      r_state <= w_state_nxt;
      m_ack <= 1'b0;
      if (w_cap) begin
        r_addr <= m_addr;
        r_data <= m_data_in;
        r_bytesel <= m_bytesel;
        r_wr <= m_wr_en;
        r_wait_cnt <= WAIT_CNT_W'(WAIT_STATES);
`ifdef SRAM_RESPONDER_POSTED_WRITE_EN
        m_ack <= m_wr_en;
        r_wack_blk <= m_wr_en;
`else
        r_wack_blk <= 1'b0;
`endif
      end else if (r_state == ACCESS && !w_last)
        r_wait_cnt <= r_wait_cnt - WAIT_CNT_W'(1);
      // a withdrawn request loses its ack, but read data is still captured
      if (w_last) begin
        m_ack <= m_access & ~r_wack_blk;
        if (!r_wr) m_data_out <= sram_dq_i;
      end
    end
  sram_pin_ctrl u_pins (
    .clk(clk),
    .rst(reset),
    .i_state(r_state),
    .i_state_nxt(w_state_nxt),
    .i_load(w_cap),
    .i_wr(w_wr),
    .i_bytesel(w_bytesel),
    .i_addr(w_addr),
    .i_data(w_data),
    .o_addr(sram_addr),
    .o_dq_o(sram_dq_o),
    .o_dq_oe(sram_dq_oe),
    .o_ce_n(sram_ce_n),
    .o_oe_n(sram_oe_n),
    .o_we_n(sram_we_n),
    .o_ub_n(sram_ub_n),
    .o_lb_n(sram_lb_n)
  );
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed transfers checked every cycle against a timing-rule model of the responder.
module tb_sram_responder;
  localparam int WS = 1;
`ifdef SRAM_RESPONDER_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic [19:1] m_addr = '0;
  logic [15:0] m_data_in = '0, m_data_out, sram_dq_o, sram_dq_i = '0;
  logic m_access = 1'b0, m_ack, m_wr_en = 1'b0;
  logic [1:0] m_bytesel = '0;
  logic [18:0] sram_addr;
  logic sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  int n_chk = 0, n_fail = 0;
  sram_responder #(.WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .m_addr(m_addr), .m_data_in(m_data_in), .m_data_out(m_data_out),
    .m_access(m_access), .m_ack(m_ack), .m_wr_en(m_wr_en), .m_bytesel(m_bytesel),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );
  always #5 clk = ~clk;
  logic [15:0] mem [logic [18:0]];
  function automatic logic [15:0] rd(input logic [18:0] a);
    return mem.exists(a) ? mem[a] : (a[15:0] ^ 16'h5A5A);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // external SRAM: drives read data while selected, commits enabled lanes while we_n is low
  always @(negedge clk) sram_dq_i = (!sram_ce_n && !sram_oe_n) ? rd(sram_addr) : 16'h0000;
  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n) begin
      logic [15:0] w;
      w = rd(sram_addr);
      if (!sram_ub_n) w[15:8] = sram_dq_o[15:8];
      if (!sram_lb_n) w[7:0] = sram_dq_o[7:0];
      mem[sram_addr] = w;
    end
  int cyc = 0, t0 = -1;
  logic x_wr = 1'b0, acc_last = 1'b0;
  logic [1:0] x_bs = '0;
  logic [18:0] e_addr = '0;
  logic [15:0] e_dout = '0, e_dqo = '0;
  always @(posedge clk) begin
    if (reset) begin
      t0 = -1; e_dout = '0; e_addr = '0; e_dqo = '0;
    end else begin
      if (t0 >= 0 && cyc - t0 == 1 + WS) begin
        acc_last = m_access;
        if (!x_wr) e_dout = rd(e_addr);
      end
      if ((t0 < 0 || cyc - t0 >= 4 + WS) && m_access) begin
        t0 = cyc; x_wr = m_wr_en; x_bs = m_bytesel; e_addr = m_addr; e_dqo = m_data_in;
      end
    end
    cyc++;
  end
  always @(negedge clk) begin
    int off;
    logic ea, eack;
    off = (t0 < 0) ? -1 : cyc - t0;
    ea = !reset && off >= 1 && off <= 1 + WS;
    eack = !reset && ((off == 2 + WS && acc_last && !(POSTED && x_wr)) || (POSTED && x_wr && off == 1));
    chk("ce_n", sram_ce_n, !ea);
    chk("oe_n", sram_oe_n, !(ea && !x_wr));
    chk("we_n", sram_we_n, !(ea && x_wr && off >= 2));
    chk("ub_n", sram_ub_n, !(ea && x_bs[1]));
    chk("lb_n", sram_lb_n, !(ea && x_bs[0]));
    chk("dq_oe", sram_dq_oe, ea && x_wr);
    chk("m_ack", m_ack, eack);
    chk("m_data_out", m_data_out, reset ? 16'h0 : e_dout);
    chk("sram_addr", sram_addr, reset ? 19'h0 : e_addr);
    chk("sram_dq_o", sram_dq_o, reset ? 16'h0 : e_dqo);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic wr, input logic [18:0] a, input logic [15:0] d, input logic [1:0] bs,
                     input int drop, output int ack_at, output int n_ack, output int oe_cnt,
                     output int we_cnt, output int we_at, output logic ub2, output logic lb2);
    ack_at = -1; n_ack = 0; oe_cnt = 0; we_cnt = 0; we_at = -1; ub2 = 1'b1; lb2 = 1'b1;
    m_access = 1'b1; m_wr_en = wr; m_addr = a; m_data_in = d; m_bytesel = bs;
    for (int n = 1; n <= 4 + WS; n++) begin
      tick();
      if (m_ack) begin n_ack++; ack_at = n; end
      if (!sram_oe_n) oe_cnt++;
      if (!sram_we_n) begin we_cnt++; we_at = n; end
      if (n == 2) begin ub2 = sram_ub_n; lb2 = sram_lb_n; end
      if (n >= drop) m_access = 1'b0;
    end
  endtask
  initial begin
    int aa, na, oc, wc, wa;
    logic u2, l2;
    mem[19'h12345] = 16'hBEEF;
    repeat (3) tick();
    chk("rst_dout", m_data_out, 16'h0);
    chk("rst_ce_n", sram_ce_n, 1'b1);
    reset = 1'b0;
    repeat (2) tick();
    req(1'b0, 19'h12345, 16'h0, 2'b11, 4 + WS, aa, na, oc, wc, wa, u2, l2);
    chk("rd_ack_cycle", aa, 3);
    chk("rd_ack_count", na, 1);
    chk("rd_data", m_data_out, 16'hBEEF);
    chk("rd_oe_cycles", oc, 2);
    tick();
    req(1'b1, 19'h00010, 16'hA55A, 2'b10, 4 + WS, aa, na, oc, wc, wa, u2, l2);
    chk("bw_we_count", wc, 1);
    chk("bw_we_cycle", wa, 2);
    chk("bw_ub_n", u2, 1'b0);
    chk("bw_lb_n", l2, 1'b1);
    chk("bw_dout_kept", m_data_out, 16'hBEEF);
    req(1'b0, 19'h00010, 16'h0, 2'b11, 4 + WS, aa, na, oc, wc, wa, u2, l2);
    chk("bw_readback", m_data_out, 16'hA54A);
    req(1'b1, 19'h00200, 16'h1234, 2'b11, 4 + WS, aa, na, oc, wc, wa, u2, l2);
    chk("held_ack_count", na, 1);
    chk("held_we_count", wc, WS);
    req(1'b0, 19'h00200, 16'h0, 2'b01, 4 + WS, aa, na, oc, wc, wa, u2, l2);
    chk("next_at_ack2", aa, 3);
    chk("held_readback", m_data_out, 16'h1234);
    req(1'b0, 19'h00777, 16'h0, 2'b11, 1, aa, na, oc, wc, wa, u2, l2);
    chk("wd_ack_count", na, 0);
    chk("wd_data", m_data_out, 16'h5D2D);
    req(1'b0, 19'h12345, 16'h0, 2'b11, 4 + WS, aa, na, oc, wc, wa, u2, l2);
    chk("after_wd_ack", aa, 3);
    chk("after_wd_data", m_data_out, 16'hBEEF);
    m_access = 1'b1; m_wr_en = 1'b1; m_addr = 19'h00055; m_data_in = 16'hFFFF; m_bytesel = 2'b11;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("mr_ce_n", sram_ce_n, 1'b1);
    chk("mr_we_n", sram_we_n, 1'b1);
    chk("mr_dq_oe", sram_dq_oe, 1'b0);
    chk("mr_dout", m_data_out, 16'h0);
    tick();
    reset = 1'b0; m_access = 1'b0;
    na = 0;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (m_ack) na++;
    end
    chk("mr_no_ack", na, 0);
    req(1'b0, 19'h12345, 16'h0, 2'b11, 4 + WS, aa, na, oc, wc, wa, u2, l2);
    chk("mr_next_ack", aa, 3);
    chk("mr_next_data", m_data_out, 16'hBEEF);
`ifdef SRAM_RESPONDER_POSTED_WRITE_EN
    m_access = 1'b1; m_wr_en = 1'b1; m_addr = 19'h00300; m_data_in = 16'hC3C3; m_bytesel = 2'b11;
    tick();
    chk("pw_ack_c1", m_ack, 1'b1);
    tick();
    m_access = 1'b0;
    tick();
    m_access = 1'b1; m_wr_en = 1'b0;
    aa = -1;
    for (int n = 4; n <= 12; n++) begin
      tick();
      if (m_ack && aa < 0) begin aa = n; m_access = 1'b0; end
    end
    chk("pw_rd_ack", aa, 7 + WS);
    chk("pw_rd_data", m_data_out, 16'hC3C3);
`endif
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_responder.md
# sram_responder

Memory-side responder for the unified `mem_m_*` bus driven by the Harvard arbiter. It accepts one word request at a time and runs a single external async SRAM cycle (16-bit, 512K words). It returns read data and a one-cycle ack. Wait states are parameterised. Optionally, writes are posted so the ack returns early.

## Interface
Parameters:
- `WAIT_STATES`, default 1: extra SRAM access cycles per transfer. Legal range 1..15.

Ports (name, direction, width, meaning):
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `m_addr` in 19 [19:1]: word address.
- `m_data_in` in 16: write data from the master.
- `m_data_out` out 16: registered read data.
- `m_access` in 1: request, held high until ack is seen.
- `m_ack` out 1: one-cycle registered completion pulse.
- `m_wr_en` in 1: 1 = write.
- `m_bytesel` in 2: byte enables, bit 1 = upper byte.
- `sram_addr` out 19: SRAM address (`m_addr[19:1]`).
- `sram_dq_o` out 16, `sram_dq_i` in 16, `sram_dq_oe` out 1: bidirectional data split.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_ub_n`, `sram_lb_n` out 1 each: active-low SRAM strobes.

## Operation
- States:
  - IDLE: sample the request.
  - ACCESS: SRAM cycle.
  - ACK: pulse the ack.
  - RECOVER: ignore the request.
- IDLE: when `m_access`=1, capture addr, data, wr_en and bytesel into holding registers. Go to ACCESS with `wait_cnt`=WAIT_STATES.
- ACCESS: lasts WAIT_STATES+1 cycles. `wait_cnt` decrements to 0; leave ACCESS on the cycle it reads 0.
  - Read:
    - `ce_n`=0 and `oe_n`=0 throughout.
    - `ub_n`/`lb_n` = ~bytesel.
    - `sram_dq_i` is latched into `m_data_out` on the last ACCESS edge, as a full word.
  - Write:
    - `dq_oe`=1 and `ce_n`=0 throughout.
    - `we_n`=0 from the 2nd ACCESS cycle through the last; it is high in the 1st cycle for address setup.
    - Only the byte lanes set in bytesel are enabled.
- ACK: `m_ack`=1 for one cycle, only if `m_access` is still 1. If the request was withdrawn, suppress the ack; a write is still committed. All strobes are inactive and `dq_oe`=0.
- RECOVER: one cycle, then IDLE. `m_access` is ignored because the master only sees the registered ack here and still presents the old request.
- `m_data_out` holds its value until the next read completes; writes never change it.
- Reset (also mid-transfer):
  - State = IDLE; `m_ack`=0; `m_data_out`=0.
  - `sram_ce_n`/`oe_n`/`we_n`/`ub_n`/`lb_n` = 1; `sram_dq_oe`=0.
  - `sram_addr`=0; `sram_dq_o`=0.
  - The interrupted SRAM cycle is abandoned. No ack is issued.

## Timing
- Capture at cycle 0 (IDLE, `m_access`=1).
- ACCESS occupies cycles 1..1+WAIT_STATES.
- `m_ack` is high in cycle 2+WAIT_STATES, i.e. cycle 3 with the default.
- RECOVER is cycle 3+WAIT_STATES. The earliest next capture is ack+2.
- Throughput: one transfer per WAIT_STATES+4 cycles.
- All SRAM outputs are registered and glitch-free. `sram_dq_oe` is never 1 while `sram_oe_n`=0.

## Configuration
- `SRAM_RESPONDER_POSTED_WRITE_EN` defined:
  - A write is acked in cycle 1, while the SRAM write continues through ACCESS.
  - A write-ack-blocked flag keeps a second ack from being issued for that write in ACK.
  - The next capture waits for both ack+2 and the end of RECOVER.
  - Reads are unchanged.
- Macro undefined: writes are acked in ACK like reads.

## Structure
- Package `sram_responder_pkg`:
  - `resp_state_t` enum (IDLE, ACCESS, ACK, RECOVER).
  - `WAIT_CNT_W`=4.
  - Strobe-inactive reset constants.
- Sub-module `sram_pin_ctrl`: registers all SRAM outputs from next-state decode and owns the `dq_oe` interlock.
- The top module holds the FSM, the wait counter and the capture registers.

## Test plan
- Read: WAIT_STATES=1, SRAM model returns 16'hBEEF at addr 19'h12345; request held -> `m_ack` in cycle 3, `m_data_out`=16'hBEEF, `oe_n` low in cycles 1–2.
- Byte write: addr 19'h00010, bytesel 2'b10, data 16'hA55A -> `we_n` low in cycle 2 only, `ub_n`=0, `lb_n`=1; a later read of that address returns 16'hA5xx with the low byte preserved.
- Held request: `m_access` kept high through the ack+1 cycle -> exactly one SRAM cycle and one ack; a new request at ack+2 is captured.
- Withdrawn request: `m_access` dropped during ACCESS of a read -> no `m_ack`, `m_data_out` updated, FSM returns to IDLE through RECOVER.
- Reset mid-write: `reset` pulsed in the 2nd ACCESS cycle -> all strobes 1, `dq_oe`=0, no ack, next request handled normally.
- Posted write (macro defined): write -> `m_ack` in cycle 1; a read issued at cycle 3 is captured only after RECOVER and returns the written data.
